// File: rtl/fetch_pkg.sv
// Shared types and next-PC helper for the decoupled fetch queue.
package fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_INC = 32'd4;

    // One buffered fetch result as delivered to decode.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    // Redirect target. A jump wins over a branch. All arithmetic wraps at 2^32.
    function automatic logic [XLEN-1:0] calc_npc(
        input logic [XLEN-1:0] redir_pc,
        input logic [25:0]     target,
        input logic [15:0]     imm16,
        input logic            ExtOp,
        input logic            jump
    );
        logic [XLEN-1:0] imm_ext;
        imm_ext = ExtOp ? {{16{imm16[15]}}, imm16} : {16'h0000, imm16};
        if (jump) begin
            calc_npc = {redir_pc[31:28], target, 2'b00};
        end else begin
            calc_npc = redir_pc + PC_INC + (imm_ext << 2);
        end
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Response buffer between instruction memory and decode.
// Flush takes priority over push and pop in the same cycle.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    input  logic                   flush,
    output fetch_entry_t           head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // Push while full is fine when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    // Storage write; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Decoupled fetch stage: in-order requests to a pipelined instruction memory,
// credit-limited to QDEPTH outstanding+buffered, responses queued for decode.
// Taken redirects flush the queue and drop responses still in flight.
// Optional: define FETCH_QUEUE_PERF_EN to add perf_redirects/perf_stall_cycles.
module fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              IMEM_AW  = 5,
    parameter int              QDEPTH   = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic               imem_rsp_valid,
    input  logic [31:0]        imem_rsp_data,
    output logic               inst_valid,
    input  logic               inst_ready,
    output logic [31:0]        inst,
    output logic [31:0]        inst_pc,
    input  logic               redirect_valid,
    input  logic [31:0]        redir_pc,
    input  logic               branch,
    input  logic               zero,
    input  logic               jump,
    input  logic               ExtOp,
    input  logic [25:0]        target,
    input  logic [15:0]        imm16
`ifdef FETCH_QUEUE_PERF_EN
    ,
    output logic [31:0]        perf_redirects,
    output logic [31:0]        perf_stall_cycles
`endif
);

    import fetch_pkg::*;

    localparam int CW = $clog2(QDEPTH) + 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   rsp_pc;
    logic [31:0]   npc;
    logic [CW-1:0] inflight;
    logic [CW-1:0] discard;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   occupancy;
    logic          take;
    logic          req_ok;
    logic          req_fire;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    fetch_entry_t  push_entry;
    fetch_entry_t  head_entry;

    assign take      = redirect_valid & (jump | (branch & zero));
    assign npc       = calc_npc(redir_pc, target, imm16, ExtOp, jump);
    assign occupancy = {1'b0, inflight} + {1'b0, fifo_count};

    // Every issued request owns a queue slot, so the queue can never overflow.
    assign req_ok         = ~take & ~fifo_full & (occupancy < (CW+1)'(QDEPTH));
    assign req_fire       = req_ok & imem_req_ready;
    assign imem_req_valid = reset & req_ok;
    assign imem_addr      = fetch_pc[IMEM_AW+1:2];

    assign push       = imem_rsp_valid & (discard == '0) & ~take;
    assign pop        = ~fifo_empty & inst_ready;
    assign push_entry = '{pc: rsp_pc, inst: imem_rsp_data};

    assign inst_valid = ~fifo_empty;
    assign inst       = fifo_empty ? '0 : head_entry.inst;
    assign inst_pc    = fifo_empty ? '0 : head_entry.pc;

    fetch_fifo #(
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (take),
        .head      (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // PC tracking, credit accounting and stale-response discard after redirects.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            inflight <= '0;
            discard  <= '0;
        end else begin
            inflight <= inflight + CW'(req_fire) - CW'(imem_rsp_valid);
            if (take) begin
                fetch_pc <= npc;
                rsp_pc   <= npc;
                discard  <= inflight - CW'(imem_rsp_valid);
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + PC_INC;
                end
                if (push) begin
                    rsp_pc <= rsp_pc + PC_INC;
                end
                if (imem_rsp_valid && (discard != '0)) begin
                    discard <= discard - CW'(1);
                end
            end
        end
    end

`ifdef FETCH_QUEUE_PERF_EN
    // Free-running event counters: taken redirects and decode-starved cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_redirects    <= '0;
            perf_stall_cycles <= '0;
        end else begin
            perf_redirects    <= perf_redirects + 32'(take);
            perf_stall_cycles <= perf_stall_cycles + 32'(~inst_valid & inst_ready);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue with a fixed-latency pipelined memory model.
module tb_fetch_queue;

    localparam int IMEM_AW = 8;
    localparam int QDEPTH  = 4;

    logic               clk   = 1'b0;
    logic               reset = 1'b1;
    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [IMEM_AW-1:0] imem_addr;
    logic               imem_rsp_valid;
    logic [31:0]        imem_rsp_data;
    logic               inst_valid;
    logic               inst_ready;
    logic [31:0]        inst;
    logic [31:0]        inst_pc;
    logic               redirect_valid;
    logic [31:0]        redir_pc;
    logic               branch;
    logic               zero;
    logic               jump;
    logic               ExtOp;
    logic [25:0]        target;
    logic [15:0]        imm16;
`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0]        perf_redirects;
    logic [31:0]        perf_stall_cycles;
`endif

    typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;
    typedef struct { int due; logic [IMEM_AW-1:0] addr; } mreq_t;

    exp_t  exp_q[$];
    mreq_t mq[$];
    int    cyc      = 0;
    int    mem_lat  = 1;
    int    n_checks = 0;
    int    n_errors = 0;

    fetch_queue #(
        .XLEN     (32),
        .IMEM_AW  (IMEM_AW),
        .QDEPTH   (QDEPTH),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redir_pc       (redir_pc),
        .branch         (branch),
        .zero           (zero),
        .jump           (jump),
        .ExtOp          (ExtOp),
        .target         (target),
        .imm16          (imm16)
`ifdef FETCH_QUEUE_PERF_EN
        ,
        .perf_redirects    (perf_redirects),
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [7:0] a);
        return {8'h5A, 16'h0000, a};
    endfunction

    // Memory: requests accepted in cycle c answer in cycle c+mem_lat, in order.
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= '0;
        end else begin
            if (imem_req_valid && imem_req_ready) begin
                mq.push_back('{due: cyc + mem_lat, addr: imem_addr});
            end
            if (mq.size() > 0 && mq[0].due == cyc + 1) begin
                imem_rsp_valid <= 1'b1;
                imem_rsp_data  <= mem_word(mq[0].addr);
                void'(mq.pop_front());
            end else begin
                imem_rsp_valid <= 1'b0;
            end
        end
    end

    task automatic load_stream(input logic [31:0] start, input int n);
        logic [31:0] p;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            p = start + 32'(4 * i);
            exp_q.push_back('{pc: p, inst: mem_word(p[9:2])});
        end
    endtask

    task automatic clear_redirect();
        redirect_valid = 1'b0;
        branch = 1'b0;
        zero   = 1'b0;
        jump   = 1'b0;
        ExtOp  = 1'b0;
    endtask

    // Leaves the bench 2 time units into cycle 0, the cycle reset releases in.
    task automatic apply_reset(input int lat, input logic rdy);
        @(posedge clk); #1;
        reset = 1'b0;
        clear_redirect();
        inst_ready = rdy;
        mem_lat = lat;
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        load_stream(32'h0, 64);
        #1;
    endtask

    task automatic test_reset();
        #3;
        n_checks++;
        if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_valids: req_valid=%b inst_valid=%b, required 0 0", imem_req_valid, inst_valid);
        end
        n_checks++;
        if (inst_pc !== 32'h0 || inst !== 32'h0 || imem_addr !== 8'h0) begin
            n_errors++;
            $display("FAIL reset_data: inst_pc=%h inst=%h addr=%h, required all 0", inst_pc, inst, imem_addr);
        end
`ifdef FETCH_QUEUE_PERF_EN
        n_checks++;
        if (perf_redirects !== 32'h0 || perf_stall_cycles !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_perf: redirects=%0d stalls=%0d, required 0 0", perf_redirects, perf_stall_cycles);
        end
`endif
        @(posedge clk); #1;
        reset = 1'b1;
        inst_ready = 1'b1;
        mem_lat = 1;
        load_stream(32'h0, 64);
        #1;
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 8'h00 || inst_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL release_first_req: req_valid=%b addr=%h inst_valid=%b, required 1 00 0", imem_req_valid, imem_addr, inst_valid);
        end
    endtask

    task automatic test_stream();
        exp_t e;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk); #2;
            n_checks++;
            if (imem_req_valid !== 1'b1 || imem_addr !== 8'(k)) begin
                n_errors++;
                $display("FAIL stream_req c%0d: req_valid=%b addr=%h, required 1 %h", k, imem_req_valid, imem_addr, 8'(k));
            end
            n_checks++;
            if (inst_valid !== (k >= 2)) begin
                n_errors++;
                $display("FAIL stream_latency c%0d: inst_valid=%b, required %b", k, inst_valid, (k >= 2));
            end
`ifdef FETCH_QUEUE_PERF_EN
            if (k == 2) begin
                n_checks++;
                if (perf_stall_cycles !== 32'd2) begin
                    n_errors++;
                    $display("FAIL perf_stall: got %0d, required 2", perf_stall_cycles);
                end
            end
`endif
            if (inst_valid && inst_ready) begin
                n_checks++;
                e = exp_q.pop_front();
                if (inst_pc !== e.pc || inst !== e.inst) begin
                    n_errors++;
                    $display("FAIL stream_pop c%0d: pc=%h inst=%h, required pc=%h inst=%h", k, inst_pc, inst, e.pc, e.inst);
                end
            end
        end
    endtask

    task automatic test_stall();
        exp_t e;
        int   fires;
        int   head_bad;
        int   pops;
        apply_reset(1, 1'b0);
        fires = (imem_req_valid && imem_req_ready) ? 1 : 0;
        head_bad = 0;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #2;
            if (imem_req_valid && imem_req_ready) fires++;
            if (inst_valid && (inst_pc !== 32'h0 || inst !== mem_word(8'h00))) head_bad++;
        end
        n_checks++;
        if (fires !== QDEPTH) begin
            n_errors++;
            $display("FAIL stall_req_count: issued %0d, required %0d", fires, QDEPTH);
        end
        n_checks++;
        if (imem_req_valid !== 1'b0 || inst_valid !== 1'b1 || inst_pc !== 32'h0) begin
            n_errors++;
            $display("FAIL stall_state: req_valid=%b inst_valid=%b pc=%h, required 0 1 0", imem_req_valid, inst_valid, inst_pc);
        end
        n_checks++;
        if (head_bad !== 0) begin
            n_errors++;
            $display("FAIL stall_head_stable: head changed in %0d cycles, required 0", head_bad);
        end
        pops = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            inst_ready = 1'b1;
            #1;
            if (k == 0) begin
                n_checks++;
                if (imem_req_valid !== 1'b0) begin
                    n_errors++;
                    $display("FAIL stall_full_credit: req_valid=%b, required 0", imem_req_valid);
                end
            end
            if (inst_valid && inst_ready) begin
                pops++;
                n_checks++;
                e = exp_q.pop_front();
                if (inst_pc !== e.pc || inst !== e.inst) begin
                    n_errors++;
                    $display("FAIL stall_pop r%0d: pc=%h inst=%h, required pc=%h inst=%h", k, inst_pc, inst, e.pc, e.inst);
                end
            end
        end
        n_checks++;
        if (pops !== 12) begin
            n_errors++;
            $display("FAIL stall_resume_rate: %0d pops in 12 cycles, required 12", pops);
        end
    endtask

    task automatic test_jump();
        exp_t e;
        apply_reset(4, 1'b1);
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (k == 3) begin
                redirect_valid = 1'b1;
                jump     = 1'b1;
                branch   = 1'b1;
                zero     = 1'b1;
                redir_pc = 32'h0000_0010;
                target   = 26'h000_0040;
                imm16    = 16'h0010;
            end else begin
                clear_redirect();
            end
            #1;
            if (k == 3) begin
                n_checks++;
                if (imem_req_valid !== 1'b0) begin
                    n_errors++;
                    $display("FAIL jump_no_req: req_valid=%b, required 0", imem_req_valid);
                end
            end
            if (k == 4) begin
                n_checks++;
                if (imem_req_valid !== 1'b1 || imem_addr !== 8'h40) begin
                    n_errors++;
                    $display("FAIL jump_target_addr: req_valid=%b addr=%h, required 1 40", imem_req_valid, imem_addr);
                end
            end
            if (k >= 4) begin
                n_checks++;
                if (inst_valid !== (k >= 9)) begin
                    n_errors++;
                    $display("FAIL jump_drop c%0d: inst_valid=%b, required %b", k, inst_valid, (k >= 9));
                end
            end
            if (inst_valid && inst_ready) begin
                n_checks++;
                e = exp_q.pop_front();
                if (inst_pc !== e.pc || inst !== e.inst) begin
                    n_errors++;
                    $display("FAIL jump_pop c%0d: pc=%h inst=%h, required pc=%h inst=%h", k, inst_pc, inst, e.pc, e.inst);
                end
            end
            if (k == 3) load_stream(32'h0000_0100, 64);
        end
    endtask

    task automatic test_branch();
        exp_t e;
        apply_reset(1, 1'b1);
        for (int k = 1; k <= 27; k++) begin
            @(posedge clk); #1;
            clear_redirect();
            redir_pc = 32'h0000_0020;
            imm16    = 16'hFFFE;
            if (k == 6 || k == 15 || k == 21) begin
                redirect_valid = 1'b1;
                branch = 1'b1;
                zero   = (k != 15);
                ExtOp  = (k != 21);
            end
            #1;
            if (k == 6 || k == 21) begin
                n_checks++;
                if (imem_req_valid !== 1'b0 || inst_valid !== 1'b1) begin
                    n_errors++;
                    $display("FAIL branch_take c%0d: req_valid=%b inst_valid=%b, required 0 1", k, imem_req_valid, inst_valid);
                end
            end
            if (k == 7 || k == 22) begin
                n_checks++;
                if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 8'h07) begin
                    n_errors++;
                    $display("FAIL branch_flush c%0d: inst_valid=%b req_valid=%b addr=%h, required 0 1 07", k, inst_valid, imem_req_valid, imem_addr);
                end
            end
            if (k == 15 || k == 16) begin
                n_checks++;
                if (imem_req_valid !== 1'b1 || inst_valid !== 1'b1) begin
                    n_errors++;
                    $display("FAIL branch_not_taken c%0d: req_valid=%b inst_valid=%b, required 1 1", k, imem_req_valid, inst_valid);
                end
            end
            if (inst_valid && inst_ready) begin
                n_checks++;
                e = exp_q.pop_front();
                if (inst_pc !== e.pc || inst !== e.inst) begin
                    n_errors++;
                    $display("FAIL branch_pop c%0d: pc=%h inst=%h, required pc=%h inst=%h", k, inst_pc, inst, e.pc, e.inst);
                end
            end
            if (k == 6)  load_stream(32'h0000_001C, 64);
            if (k == 21) load_stream(32'h0004_001C, 64);
        end
        clear_redirect();
`ifdef FETCH_QUEUE_PERF_EN
        n_checks++;
        if (perf_redirects !== 32'd2) begin
            n_errors++;
            $display("FAIL perf_redirects: got %0d, required 2", perf_redirects);
        end
`endif
    endtask

    task automatic test_reset_mid();
        exp_t e;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        n_checks++;
        if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0 || imem_addr !== 8'h0) begin
            n_errors++;
            $display("FAIL midreset_outputs: req_valid=%b inst_valid=%b inst=%h pc=%h addr=%h, required all 0",
                     imem_req_valid, inst_valid, inst, inst_pc, imem_addr);
        end
`ifdef FETCH_QUEUE_PERF_EN
        n_checks++;
        if (perf_redirects !== 32'h0 || perf_stall_cycles !== 32'h0) begin
            n_errors++;
            $display("FAIL midreset_perf: redirects=%0d stalls=%0d, required 0 0", perf_redirects, perf_stall_cycles);
        end
`endif
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        load_stream(32'h0, 64);
        #1;
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 8'h00) begin
            n_errors++;
            $display("FAIL midreset_first_req: req_valid=%b addr=%h, required 1 00", imem_req_valid, imem_addr);
        end
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #2;
            n_checks++;
            if (inst_valid !== (k >= 2)) begin
                n_errors++;
                $display("FAIL midreset_latency c%0d: inst_valid=%b, required %b", k, inst_valid, (k >= 2));
            end
            if (inst_valid && inst_ready) begin
                n_checks++;
                e = exp_q.pop_front();
                if (inst_pc !== e.pc || inst !== e.inst) begin
                    n_errors++;
                    $display("FAIL midreset_pop c%0d: pc=%h inst=%h, required pc=%h inst=%h", k, inst_pc, inst, e.pc, e.inst);
                end
            end
        end
    endtask

    initial begin
        imem_req_ready = 1'b1;
        inst_ready     = 1'b0;
        redir_pc       = '0;
        target         = '0;
        imm16          = '0;
        clear_redirect();
        #1 reset = 1'b0;
        test_reset();
        test_stream();
        test_stall();
        test_jump();
        test_branch();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
